// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - IF stage control, program-load and IF/ID bundle
interface instruction_fetch_if #(
   parameter int NB_DATA      = 32,
   parameter int NB_IMEM_ADDR = 8
);
   logic                    enable;
   logic                    stall;
   logic                    jump;
   logic [NB_DATA-1:0]      jump_addr;
   logic                    imem_wr_en;
   logic [NB_IMEM_ADDR-1:0] imem_wr_addr;
   logic [NB_DATA-1:0]      imem_wr_data;
   logic [NB_DATA-1:0]      instruction;
   logic [NB_DATA-1:0]      pc4;
   logic [NB_DATA-1:0]      pc;
   logic                    halted;

   modport master (
      output enable, stall, jump, jump_addr, imem_wr_en, imem_wr_addr, imem_wr_data,
      input  instruction, pc4, pc, halted
   );

   modport slave (
      input  enable, stall, jump, jump_addr, imem_wr_en, imem_wr_addr, imem_wr_data,
      output instruction, pc4, pc, halted
   );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS IF stage: PC, instruction memory, IF/ID register
module instruction_fetch #(
   parameter int NB_DATA      = 32,
   parameter int NB_IMEM_ADDR = 8,
   parameter int IMEM_DEPTH   = 2**NB_IMEM_ADDR
) (
   input logic               clk,
   input logic               reset,
   instruction_fetch_if.slave bus
);
   localparam logic [NB_DATA-1:0] HALT_WORD = {NB_DATA{1'b1}};
   localparam logic [NB_DATA-1:0] PC_STEP   = NB_DATA'(4);

   logic [NB_DATA-1:0] imem [IMEM_DEPTH];
   logic [NB_DATA-1:0] pc_q;
   logic [NB_DATA-1:0] instr_q;
   logic [NB_DATA-1:0] pc4_q;
   logic               halted_q;
   logic [NB_DATA-1:0] fetched;
   logic [NB_DATA-1:0] pc_plus4;

   // Program load is deliberately outside reset/enable so a loaded image survives reset.
   always_ff @(posedge clk) begin
      if (bus.imem_wr_en) begin
         imem[bus.imem_wr_addr] <= bus.imem_wr_data;
      end
   end

   always_comb begin
      fetched  = imem[pc_q[NB_IMEM_ADDR+1:2]];
      pc_plus4 = pc_q + PC_STEP;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= '0;
         instr_q  <= '0;
         pc4_q    <= '0;
         halted_q <= 1'b0;
      end else if (bus.enable && !bus.stall) begin
         if (bus.jump) begin
            // Redirect squashes the wrong-path word, including a speculative HALT.
            pc_q     <= bus.jump_addr;
            instr_q  <= '0;
            pc4_q    <= '0;
            halted_q <= 1'b0;
         end else if (!halted_q) begin
            instr_q <= fetched;
            pc4_q   <= pc_plus4;
            if (fetched == HALT_WORD) begin
               halted_q <= 1'b1;
            end else begin
               pc_q <= pc_plus4;
            end
         end
      end
   end

   assign bus.instruction = instr_q;
   assign bus.pc4         = pc4_q;
   assign bus.pc          = pc_q;
   assign bus.halted      = halted_q;
endmodule
